sort_seq_ctrl: RTL and testbench

SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

---
 rtl/sort_seq_ctrl.sv | 88 ++++++++
 tb/tb_sort_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: loads an N-element frame, sorts it in place descending (stable insertion sort),
// then streams it out with valid/ready handshaking.
module sort_seq_ctrl #(
   parameter int N = 8,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         busy,
   output logic         done,
   output logic [7:0]   sort_cycles
);
   localparam int IW = $clog2(N);
   localparam int JW = IW + 1;
   localparam logic [IW-1:0] last_idx = IW'(N - 1);
   typedef enum logic [1:0] {LOAD, PICK, CMP, DRAIN} state_t;
   state_t state, state_nx;
   logic [W-1:0] mem [N];
   logic [W-1:0] cur;
   logic [IW-1:0] wr_ptr, rd_ptr, i, j_idx, j_up;
   logic signed [JW-1:0] j;
   logic [7:0] cnt, cnt_inc;
   logic in_fire, out_fire, j_neg, shift;
   // j runs down to -1; its low bits + 1 then wrap to slot 0 for the final insert
   assign j_neg = j[JW-1];
   assign j_idx = j[IW-1:0];
   assign j_up = j_idx + IW'(1);
   assign shift = (state == CMP) && !j_neg && (cur > mem[j_idx]);
   assign cnt_inc = (cnt == 8'hff) ? cnt : cnt + 8'd1;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= LOAD;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         LOAD:    state_nx = (in_fire && wr_ptr == last_idx) ? PICK : LOAD;
         PICK:    state_nx = CMP;
         CMP:     state_nx = shift ? CMP : (i == last_idx ? DRAIN : PICK);
         DRAIN:   state_nx = (out_fire && out_last) ? LOAD : DRAIN;
         default: state_nx = LOAD;
      endcase
   end
   always_comb begin
      in_ready = state == LOAD;
      out_valid = state == DRAIN;
      busy = state != LOAD;
      out_last = out_valid && rd_ptr == last_idx;
      out_data = mem[rd_ptr];
      in_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         i <= '0;
         j <= '0;
         cnt <= '0;
         sort_cycles <= '0;
         done <= 1'b0;
      end else begin
         done <= state == CMP && state_nx == DRAIN;
         if (in_fire) wr_ptr <= (wr_ptr == last_idx) ? '0 : wr_ptr + IW'(1);
         if (state == LOAD) begin
            i <= IW'(1);
            cnt <= '0;
         end
         if (state == PICK || state == CMP) cnt <= cnt_inc;
         if (state == PICK) j <= {1'b0, i} - JW'(1);
         if (state == CMP && shift) j <= j - JW'(1);
         if (state == CMP && !shift && i != last_idx) i <= i + IW'(1);
         if (state == CMP && state_nx == DRAIN) sort_cycles <= cnt_inc;
         if (out_fire) rd_ptr <= out_last ? '0 : rd_ptr + IW'(1);
      end
   // storage is deliberately unreset; a new frame always overwrites every slot
   always_ff @(posedge clk) begin
      if (in_fire) mem[wr_ptr] <= in_data;
      if (state == PICK) cur <= mem[i];
      if (state == CMP) mem[j_up] <= shift ? mem[j_idx] : cur;
   end
endmodule

// File: tb/tb_sort_seq_ctrl.sv
// tb_sort_seq_ctrl: directed frames with hand-computed sorted outputs and sort latencies.
module tb_sort_seq_ctrl;
   localparam int N = 8;
   localparam int W = 8;
   typedef logic [W-1:0] frame_t [N];
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
   logic [W-1:0] in_data, out_data;
   logic [7:0] sort_cycles;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   sort_seq_ctrl #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done), .sort_cycles(sort_cycles)
   );
   task automatic load_frame(input frame_t f, input logic keep, input string name);
      for (int k = 0; k < N; k++) begin
         in_data = f[k];
         in_valid = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s load[%0d] in_ready=%b want 1", name, k, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = keep;
      in_data = 8'hAA;
   endtask
   task automatic sort_and_check(input int exp_cyc, input string name);
      int k = 0;
      while (out_valid !== 1'b1 && k < 300) begin
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s sort flags cyc %0d: in_ready=%b busy=%b done=%b want 0 1 0", name, k, in_ready, busy, done);
         end
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s sort timeout: out_valid=%b want 1", name, out_valid);
      end
      checks++;
      if (k != exp_cyc) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, k, exp_cyc);
      end
      checks++;
      if (sort_cycles !== 8'(exp_cyc)) begin
         errors++;
         $display("FAIL %s sort_cycles: got %0d want %0d", name, sort_cycles, exp_cyc);
      end
   endtask
   task automatic drain_and_check(input frame_t e, input logic [3:0] pat, input string name);
      int idx = 0;
      int c = 0;
      while (idx < N && c < 100) begin
         out_ready = pat[c % 4];
         checks++;
         if (out_valid !== 1'b1 || out_data !== e[idx] || out_last !== (idx == N - 1) || done !== (c == 0) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s drain cyc %0d: valid=%b data=%0d last=%b done=%b in_ready=%b want 1 %0d %b %b 0",
                     name, c, out_valid, out_data, out_last, done, in_ready, e[idx], idx == N - 1, c == 0);
         end
         if (out_ready) idx++;
         @(posedge clk); #1;
         c++;
      end
      out_ready = 1'b1;
      checks++;
      if (idx != N) begin
         errors++;
         $display("FAIL %s drain count: got %0d want %0d", name, idx, N);
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s after drain: in_ready=%b busy=%b out_valid=%b want 1 0 0", name, in_ready, busy, out_valid);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h55;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || sort_cycles !== 8'd0) begin
         errors++;
         $display("FAIL reset state: in_ready=%b busy=%b out_valid=%b out_last=%b done=%b sort_cycles=%0d want 1 0 0 0 0 0",
                  in_ready, busy, out_valid, out_last, done, sort_cycles);
      end
      rst = 1'b0;
      in_valid = 1'b0;
   endtask
   task automatic test_ascending();
      frame_t f, e;
      f = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      e = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      load_frame(f, 1'b0, "ascending");
      sort_and_check(42, "ascending");
      drain_and_check(e, 4'b1111, "ascending");
   endtask
   task automatic test_descending();
      frame_t f;
      f = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      load_frame(f, 1'b0, "descending");
      sort_and_check(14, "descending");
      drain_and_check(f, 4'b1111, "descending");
   endtask
   task automatic test_duplicates();
      frame_t f, e;
      f = '{8'd5, 8'd5, 8'd9, 8'd0, 8'd5, 8'd255, 8'd1, 8'd9};
      e = '{8'd255, 8'd9, 8'd9, 8'd5, 8'd5, 8'd5, 8'd1, 8'd0};
      load_frame(f, 1'b0, "duplicates");
      sort_and_check(28, "duplicates");
      drain_and_check(e, 4'b1111, "duplicates");
   endtask
   task automatic test_stall();
      frame_t f, e;
      f = '{8'd2, 8'd9, 8'd4, 8'd7, 8'd1, 8'd8, 8'd3, 8'd6};
      e = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2, 8'd1};
      load_frame(f, 1'b0, "stall");
      sort_and_check(28, "stall");
      drain_and_check(e, 4'b1001, "stall");
   endtask
   task automatic test_reset_mid();
      frame_t f, g, e;
      f = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd1, 8'd2, 8'd3, 8'd4};
      g = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4};
      e = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
      for (int k = 0; k < 4; k++) begin
         in_data = f[k];
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || sort_cycles !== 8'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset mid-load: busy=%b sort_cycles=%0d in_ready=%b want 0 0 1", busy, sort_cycles, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      load_frame(f, 1'b0, "reset_mid_pre");
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset mid-sort precheck: busy=%b want 1", busy);
      end
      rst = 1'b1;
      in_valid = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || sort_cycles !== 8'd0 || out_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset mid-sort: busy=%b sort_cycles=%0d out_valid=%b done=%b want 0 0 0 0", busy, sort_cycles, out_valid, done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      load_frame(g, 1'b0, "reset_mid");
      sort_and_check(31, "reset_mid");
      drain_and_check(e, 4'b1111, "reset_mid");
   endtask
   task automatic test_back_to_back();
      frame_t a, b, e;
      a = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      b = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
      e = '{8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
      load_frame(a, 1'b1, "b2b_first");
      sort_and_check(14, "b2b_first");
      drain_and_check(a, 4'b1111, "b2b_first");
      load_frame(b, 1'b0, "b2b_second");
      sort_and_check(42, "b2b_second");
      drain_and_check(e, 4'b1111, "b2b_second");
   endtask
   initial begin
      test_reset();
      test_ascending();
      test_descending();
      test_duplicates();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
